cpu_control: RTL and testbench

Instruction fetch/decode/sequencing controller for the 16-bit, 8-register CPU. It fetches instructions over a ready-handshaked memory port and holds them in an instruction register. Each cycle it drives the full set of datapath control strobes, register selects and immediates, and consumes the datapath's N/Z flags for conditional branches. It sits directly upstream of cpu_datapath and is its only source of control.

---
 rtl/cpu_pkg.sv | 72 +++++++
 rtl/cpu_decoder.sv | 106 ++++++++++
 rtl/cpu_control.sv | 161 ++++++++++++++++
 tb/tb_cpu_control.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit, 8-register CPU controller:
//   - opcode_e : instruction opcodes (IR[3:0])
//   - state_e  : sequencing states of cpu_control
//   - IR_*     : instruction-register field positions
//   - ctrl_t   : decoded control bundle produced by cpu_decoder
//   - sext8 / sext11 : immediate sign-extension helpers
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_MV   = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_CMP  = 4'd3,
        OP_LD   = 4'd4,
        OP_ST   = 4'd5,
        OP_MVHI = 4'd6,
        OP_J    = 4'd8,
        OP_JZ   = 4'd9,
        OP_JN   = 4'd10,
        OP_CALL = 4'd12
    } opcode_e;

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam int unsigned IR_OP_LSB    = 32'd0;
    localparam int unsigned IR_OP_MSB    = 32'd3;
    localparam int unsigned IR_I_BIT     = 32'd4;
    localparam int unsigned IR_X_LSB     = 32'd5;
    localparam int unsigned IR_X_MSB     = 32'd7;
    localparam int unsigned IR_Y_LSB     = 32'd8;
    localparam int unsigned IR_Y_MSB     = 32'd10;
    localparam int unsigned IR_IMM8_LSB  = 32'd8;
    localparam int unsigned IR_IMM11_LSB = 32'd5;

    // Everything the EXEC cycle may drive, plus the ld/st markers that the
    // sequencer uses to decide whether a MEM cycle follows.
    typedef struct packed {
        logic write_y;
        logic write_imm;
        logic write_alu;
        logic write_high;
        logic write_pc;
        logic alu_sel;
        logic op_sel;
        logic set_nz;
        logic incr_pc;
        logic set_pc_rx;
        logic set_pc_imm;
        logic is_ld;
        logic is_st;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{default: 1'b0};

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext11(input logic [10:0] v);
        return {{5{v[10]}}, v};
    endfunction

endpackage

// File: rtl/cpu_decoder.sv
// ----------------------------------------------------------------------------
// cpu_decoder
// Purely combinational instruction decoder. Maps the instruction register and
// the datapath flags to the EXEC-cycle control bundle and an illegal flag.
//   ir      in  16  instruction register
//   i_n     in  1   datapath negative flag
//   i_z     in  1   datapath zero flag
//   ctrl    out     decoded control bundle (all zero for illegal words)
//   illegal out 1   opcode outside the encoding table, or mvhi with I=0
// ----------------------------------------------------------------------------
module cpu_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    input  logic        i_n,
    input  logic        i_z,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [3:0] op_s;
    logic       imm_s;

    assign op_s  = ir[IR_OP_MSB:IR_OP_LSB];
    assign imm_s = ir[IR_I_BIT];

    // Opcode decode; the I bit selects immediate operand / immediate target.
    always_comb begin
        ctrl    = CTRL_IDLE;
        illegal = 1'b0;
        case (op_s)
            OP_MV: begin
                if (imm_s) begin
                    ctrl.write_imm = 1'b1;
                end else begin
                    ctrl.write_y = 1'b1;
                end
                ctrl.incr_pc = 1'b1;
            end
            OP_ADD: begin
                ctrl.alu_sel   = imm_s;
                ctrl.write_alu = 1'b1;
                ctrl.set_nz    = 1'b1;
                ctrl.incr_pc   = 1'b1;
            end
            OP_SUB: begin
                ctrl.alu_sel   = imm_s;
                ctrl.op_sel    = 1'b1;
                ctrl.write_alu = 1'b1;
                ctrl.set_nz    = 1'b1;
                ctrl.incr_pc   = 1'b1;
            end
            OP_CMP: begin
                // Subtract for flags only; nothing is written back.
                ctrl.alu_sel = imm_s;
                ctrl.op_sel  = 1'b1;
                ctrl.set_nz  = 1'b1;
                ctrl.incr_pc = 1'b1;
            end
            OP_LD: begin
                ctrl.is_ld = 1'b1;
            end
            OP_ST: begin
                ctrl.is_st = 1'b1;
            end
            OP_MVHI: begin
                if (imm_s) begin
                    ctrl.write_high = 1'b1;
                    ctrl.incr_pc    = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_J: begin
                ctrl.set_pc_imm = imm_s;
                ctrl.set_pc_rx  = ~imm_s;
            end
            OP_JZ: begin
                if (i_z) begin
                    ctrl.set_pc_imm = imm_s;
                    ctrl.set_pc_rx  = ~imm_s;
                end else begin
                    ctrl.incr_pc = 1'b1;
                end
            end
            OP_JN: begin
                if (i_n) begin
                    ctrl.set_pc_imm = imm_s;
                    ctrl.set_pc_rx  = ~imm_s;
                end else begin
                    ctrl.incr_pc = 1'b1;
                end
            end
            OP_CALL: begin
                // Link register r7 is written in the same cycle the PC moves.
                ctrl.write_pc   = 1'b1;
                ctrl.set_pc_imm = imm_s;
                ctrl.set_pc_rx  = ~imm_s;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// ----------------------------------------------------------------------------
// cpu_control
// Fetch/decode/sequencing controller for the 16-bit, 8-register CPU. Fetches
// instruction words over a ready-handshaked memory port, holds them in the IR
// and drives every datapath control strobe. All outputs are combinational
// from state, IR, flags and i_mem_ready.
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_mem_rdata/i_mem_ready  instruction word / memory completion
//   i_n, i_z                 datapath flags
//   o_mem_rd, o_mem_wr       memory request strobes
//   o_x, o_y                 register selects IR[7:5], IR[10:8]
//   o_imm8, o_nse_imm8       IR[15:8] sign-extended / raw
//   o_imm11                  IR[15:5] sign-extended
//   o_write_*                register-file write strobes
//   o_alu_sel, o_op_sel, o_set_nz, o_mem_sel  datapath muxes
//   o_incr_pc, o_set_pc_rx, o_set_pc_imm       PC updates
//   o_halted                 illegal instruction trapped
// ----------------------------------------------------------------------------
module cpu_control
    import cpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ready,
    input  logic        i_n,
    input  logic        i_z,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [2:0]  o_x,
    output logic [2:0]  o_y,
    output logic [15:0] o_imm8,
    output logic [7:0]  o_nse_imm8,
    output logic [15:0] o_imm11,
    output logic        o_write_y,
    output logic        o_write_imm,
    output logic        o_write_alu,
    output logic        o_write_mem,
    output logic        o_write_high,
    output logic        o_write_pc,
    output logic        o_alu_sel,
    output logic        o_op_sel,
    output logic        o_set_nz,
    output logic        o_mem_sel,
    output logic        o_incr_pc,
    output logic        o_set_pc_rx,
    output logic        o_set_pc_imm,
    output logic        o_halted
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       dec_ctrl_s;
    logic        dec_illegal_s;

    cpu_decoder u_decoder (
        .ir      (ir_q),
        .i_n     (i_n),
        .i_z     (i_z),
        .ctrl    (dec_ctrl_s),
        .illegal (dec_illegal_s)
    );

    // IR field extraction is independent of state.
    assign o_x        = ir_q[IR_X_MSB:IR_X_LSB];
    assign o_y        = ir_q[IR_Y_MSB:IR_Y_LSB];
    assign o_nse_imm8 = ir_q[15:IR_IMM8_LSB];
    assign o_imm8     = sext8(ir_q[15:IR_IMM8_LSB]);
    assign o_imm11    = sext11(ir_q[15:IR_IMM11_LSB]);

    // State and instruction register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_BOOT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic and state-gated strobes.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        o_mem_rd     = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_sel    = 1'b1;
        o_write_y    = 1'b0;
        o_write_imm  = 1'b0;
        o_write_alu  = 1'b0;
        o_write_mem  = 1'b0;
        o_write_high = 1'b0;
        o_write_pc   = 1'b0;
        o_alu_sel    = 1'b0;
        o_op_sel     = 1'b0;
        o_set_nz     = 1'b0;
        o_incr_pc    = 1'b0;
        o_set_pc_rx  = 1'b0;
        o_set_pc_imm = 1'b0;
        o_halted     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                o_mem_rd = 1'b1;
                if (i_mem_ready) begin
                    ir_d    = i_mem_rdata;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (dec_illegal_s) begin
                    state_d = ST_HALT;
                end else begin
                    o_write_y    = dec_ctrl_s.write_y;
                    o_write_imm  = dec_ctrl_s.write_imm;
                    o_write_alu  = dec_ctrl_s.write_alu;
                    o_write_high = dec_ctrl_s.write_high;
                    o_write_pc   = dec_ctrl_s.write_pc;
                    o_alu_sel    = dec_ctrl_s.alu_sel;
                    o_op_sel     = dec_ctrl_s.op_sel;
                    o_set_nz     = dec_ctrl_s.set_nz;
                    o_incr_pc    = dec_ctrl_s.incr_pc;
                    o_set_pc_rx  = dec_ctrl_s.set_pc_rx;
                    o_set_pc_imm = dec_ctrl_s.set_pc_imm;
                    if (dec_ctrl_s.is_ld || dec_ctrl_s.is_st) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_MEM: begin
                // Request and address select held stable until ready; the
                // completion strobes appear only in the ready cycle.
                o_mem_sel = 1'b0;
                o_mem_rd  = dec_ctrl_s.is_ld;
                o_mem_wr  = dec_ctrl_s.is_st;
                if (i_mem_ready) begin
                    o_write_mem = dec_ctrl_s.is_ld;
                    o_incr_pc   = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_HALT: begin
                o_halted = 1'b1;
                state_d  = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control.sv
// ----------------------------------------------------------------------------
// tb_cpu_control
// Table-driven bench for cpu_control plus hand-written multi-cycle sequences
// (memory wait states, HALT trap, reset during a store).
// ----------------------------------------------------------------------------
module tb_cpu_control;

    logic        clk;
    logic        rst_n;
    logic [15:0] rdata;
    logic        ready;
    logic        n;
    logic        z;
    logic        o_mem_rd, o_mem_wr;
    logic [2:0]  o_x, o_y;
    logic [15:0] o_imm8, o_imm11;
    logic [7:0]  o_nse_imm8;
    logic        o_write_y, o_write_imm, o_write_alu, o_write_mem;
    logic        o_write_high, o_write_pc;
    logic        o_alu_sel, o_op_sel, o_set_nz, o_mem_sel;
    logic        o_incr_pc, o_set_pc_rx, o_set_pc_imm, o_halted;

    int total = 0;
    int bad   = 0;

    // Strobe word bit masks
    localparam logic [15:0] M_MRD = 16'h8000;
    localparam logic [15:0] M_MWR = 16'h4000;
    localparam logic [15:0] M_WY  = 16'h2000;
    localparam logic [15:0] M_WI  = 16'h1000;
    localparam logic [15:0] M_WA  = 16'h0800;
    localparam logic [15:0] M_WM  = 16'h0400;
    localparam logic [15:0] M_WH  = 16'h0200;
    localparam logic [15:0] M_WP  = 16'h0100;
    localparam logic [15:0] M_AS  = 16'h0080;
    localparam logic [15:0] M_OS  = 16'h0040;
    localparam logic [15:0] M_NZ  = 16'h0020;
    localparam logic [15:0] M_MS  = 16'h0010;
    localparam logic [15:0] M_IP  = 16'h0008;
    localparam logic [15:0] M_PRX = 16'h0004;
    localparam logic [15:0] M_PIM = 16'h0002;
    localparam logic [15:0] M_HLT = 16'h0001;

    cpu_control dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_mem_rdata  (rdata),
        .i_mem_ready  (ready),
        .i_n          (n),
        .i_z          (z),
        .o_mem_rd     (o_mem_rd),
        .o_mem_wr     (o_mem_wr),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_imm8       (o_imm8),
        .o_nse_imm8   (o_nse_imm8),
        .o_imm11      (o_imm11),
        .o_write_y    (o_write_y),
        .o_write_imm  (o_write_imm),
        .o_write_alu  (o_write_alu),
        .o_write_mem  (o_write_mem),
        .o_write_high (o_write_high),
        .o_write_pc   (o_write_pc),
        .o_alu_sel    (o_alu_sel),
        .o_op_sel     (o_op_sel),
        .o_set_nz     (o_set_nz),
        .o_mem_sel    (o_mem_sel),
        .o_incr_pc    (o_incr_pc),
        .o_set_pc_rx  (o_set_pc_rx),
        .o_set_pc_imm (o_set_pc_imm),
        .o_halted     (o_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] strobes_now();
        return {o_mem_rd, o_mem_wr, o_write_y, o_write_imm, o_write_alu,
                o_write_mem, o_write_high, o_write_pc, o_alu_sel, o_op_sel,
                o_set_nz, o_mem_sel, o_incr_pc, o_set_pc_rx, o_set_pc_imm,
                o_halted};
    endfunction

    // fsel: 0 none, 1 imm8, 2 imm11, 3 nse_imm8
    function automatic logic [15:0] field_now(input int fsel);
        case (fsel)
            1: return o_imm8;
            2: return o_imm11;
            3: return {8'h00, o_nse_imm8};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] word;
        logic        n;
        logic        z;
        logic [15:0] exp;
        int          fsel;
        logic [15:0] fval;
    } vec_t;

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{16'h0201, 1'b0, 1'b0, M_WA | M_NZ | M_IP | M_MS, 0, 16'h0000};         // add reg
        vecs[1]  = '{16'h0002, 1'b0, 1'b0, M_WA | M_NZ | M_OS | M_IP | M_MS, 0, 16'h0000};  // sub reg
        vecs[2]  = '{16'h0712, 1'b0, 1'b0, M_AS | M_WA | M_NZ | M_OS | M_IP | M_MS, 1, 16'h0007}; // sub imm
        vecs[3]  = '{16'h0313, 1'b0, 1'b0, M_AS | M_OS | M_NZ | M_IP | M_MS, 0, 16'h0000};  // cmp imm
        vecs[4]  = '{16'h0000, 1'b0, 1'b0, M_WY | M_IP | M_MS, 0, 16'h0000};                // mv
        vecs[5]  = '{16'hFF16, 1'b0, 1'b0, M_WH | M_IP | M_MS, 3, 16'h00FF};                // mvhi
        vecs[6]  = '{16'h8010, 1'b0, 1'b0, M_WI | M_IP | M_MS, 1, 16'hFF80};                // mvi
        vecs[7]  = '{16'h0008, 1'b0, 1'b0, M_PRX | M_MS, 0, 16'h0000};                      // jr
        vecs[8]  = '{16'h0098, 1'b0, 1'b0, M_PIM | M_MS, 2, 16'h0004};                      // j imm
        vecs[9]  = '{16'hFFB9, 1'b0, 1'b1, M_PIM | M_MS, 2, 16'hFFFD};                      // jz taken
        vecs[10] = '{16'hFFB9, 1'b0, 1'b0, M_IP | M_MS, 2, 16'hFFFD};                       // jz not taken
        vecs[11] = '{16'hFFB9, 1'b1, 1'b0, M_IP | M_MS, 0, 16'h0000};                       // jz ignores n
        vecs[12] = '{16'hFFA9, 1'b0, 1'b1, M_PRX | M_MS, 2, 16'hFFFD};                      // jz reg taken
        vecs[13] = '{16'h001A, 1'b1, 1'b0, M_PIM | M_MS, 0, 16'h0000};                      // jn taken
        vecs[14] = '{16'h001A, 1'b0, 1'b1, M_IP | M_MS, 0, 16'h0000};                       // jn not taken
        vecs[15] = '{16'h009C, 1'b0, 1'b0, M_WP | M_PIM | M_MS, 2, 16'h0004};               // call imm
        vecs[16] = '{16'h000C, 1'b0, 1'b0, M_WP | M_PRX | M_MS, 0, 16'h0000};               // callr

        rst_n = 1'b0;
        ready = 1'b1;
        rdata = 16'h0511;
        n     = 1'b0;
        z     = 1'b0;

        // Reset state and first fetch of add r0,r5 imm
        repeat (2) @(negedge clk);
        #1 chk("reset_strobes", strobes_now(), M_MS);
        chk("reset_xy", {10'd0, o_x, o_y}, 16'h0000);
        rst_n = 1'b1;
        #1 chk("boot", strobes_now(), M_MS);
        @(negedge clk);
        #1 chk("fetch0", strobes_now(), M_MRD | M_MS);
        @(negedge clk);
        #1 chk("exec_add_imm", strobes_now(), M_AS | M_WA | M_NZ | M_IP | M_MS);
        chk("exec_add_imm8", o_imm8, 16'h0005);
        @(negedge clk);

        // Table: every entry is FETCH (zero wait) then EXEC then back to FETCH
        for (int i = 0; i < 17; i++) begin
            rdata = vecs[i].word;
            ready = 1'b1;
            n     = vecs[i].n;
            z     = vecs[i].z;
            #1 chk($sformatf("fetch_v%0d", i), strobes_now(), M_MRD | M_MS);
            @(negedge clk);
            #1 chk($sformatf("exec_v%0d", i), strobes_now(), vecs[i].exp);
            if (vecs[i].fsel != 0) begin
                chk($sformatf("field_v%0d", i), field_now(vecs[i].fsel), vecs[i].fval);
            end
            @(negedge clk);
        end

        // ld r1,[r5] with three wait cycles in MEM
        rdata = 16'h0524;
        ready = 1'b1;
        #1 chk("ld_fetch", strobes_now(), M_MRD | M_MS);
        @(negedge clk);
        ready = 1'b0;
        #1 chk("ld_exec", strobes_now(), M_MS);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("ld_wait%0d", k), strobes_now(), M_MRD);
            chk($sformatf("ld_xy%0d", k), {10'd0, o_x, o_y}, {10'd0, 3'd1, 3'd5});
            @(negedge clk);
        end
        ready = 1'b1;
        #1 chk("ld_done", strobes_now(), M_MRD | M_WM | M_IP);
        @(negedge clk);

        // st zero-wait: three cycles total
        rdata = 16'h0525;
        #1 chk("st_fetch", strobes_now(), M_MRD | M_MS);
        @(negedge clk);
        #1 chk("st_exec", strobes_now(), M_MS);
        @(negedge clk);
        #1 chk("st_mem", strobes_now(), M_MWR | M_IP);
        @(negedge clk);

        // Opcode 7 traps; HALT ignores further fetch traffic
        rdata = 16'h0007;
        #1 chk("ill_fetch", strobes_now(), M_MRD | M_MS);
        @(negedge clk);
        rdata = 16'h0511;
        #1 chk("ill_exec", strobes_now(), M_MS);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            #1 chk($sformatf("halt%0d", k), strobes_now(), M_MS | M_HLT);
            @(negedge clk);
        end

        // Reset out of HALT, then reset again in the middle of a stalled store
        rst_n = 1'b0;
        #1 chk("halt_reset", strobes_now(), M_MS);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rdata = 16'h0525;
        ready = 1'b1;
        #1 chk("st2_fetch", strobes_now(), M_MRD | M_MS);
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        #1 chk("st2_wait", strobes_now(), M_MWR);
        #2 rst_n = 1'b0;
        #1 chk("st2_reset_drop", strobes_now(), M_MS);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("st2_boot", strobes_now(), M_MS);
        @(negedge clk);

        // mvhi with I=0 is illegal; the abandoned store is not retried
        rdata = 16'h0006;
        ready = 1'b1;
        #1 chk("mvhi0_fetch", strobes_now(), M_MRD | M_MS);
        @(negedge clk);
        #1 chk("mvhi0_exec", strobes_now(), M_MS);
        @(negedge clk);
        #1 chk("mvhi0_halt", strobes_now(), M_MS | M_HLT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
